// File: rtl/serial_sub_ctrl_if.sv
// Operand/result bundle for the bit-serial subtractor: start/ready handshake,
// abort, and the registered result word with its flags.
`timescale 1ns/1ps
interface serial_sub_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic             Bin_in;
  logic             abort;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             Z;
  logic             V;

  modport master (output start, A_in, B_in, Bin_in, abort,
                  input  ready, busy, done, Diff, Bout, Z, V);
  modport slave  (input  start, A_in, B_in, Bin_in, abort,
                  output ready, busy, done, Diff, Bout, Z, V);
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B - Bin over WIDTH bits, LSB first, through one full-subtractor
// cell with a registered borrow; flags are registered on entry to DONE.
`timescale 1ns/1ps
module fs_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);
endmodule

module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_sub_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d, shb_q, shb_d, acc_q, acc_d, diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             brw_q, brw_d, amsb_q, amsb_d, bmsb_q, bmsb_d;
  logic             bout_q, bout_d, z_q, z_d, v_q, v_d;
  logic             d_cell, bo_cell;
  logic [WIDTH-1:0] acc_sh;

  fs_1bit u_fs (
    .a    (sha_q[0]),
    .b    (shb_q[0]),
    .bin  (brw_q),
    .d    (d_cell),
    .bout (bo_cell)
  );

  // Accumulator after this cycle's bit lands at the MSB; on the last bit it is the full word.
  assign acc_sh = {d_cell, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    z_d     = z_q;
    v_d     = v_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          state_d = RUN;
          sha_d   = bus.A_in;
          shb_d   = bus.B_in;
          brw_d   = bus.Bin_in;
          cnt_d   = '0;
          acc_d   = '0;
          amsb_d  = bus.A_in[WIDTH-1];
          bmsb_d  = bus.B_in[WIDTH-1];
        end
      end
      RUN: begin
        if (bus.abort) begin
          // Abort beats completion; previous results stay on the outputs.
          state_d = IDLE;
        end else begin
          brw_d = bo_cell;
          sha_d = sha_q >> 1;
          shb_d = shb_q >> 1;
          acc_d = acc_sh;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = DONE;
            diff_d  = acc_sh;
            bout_d  = bo_cell;
            z_d     = (acc_sh == '0);
            v_d     = (amsb_q ^ bmsb_q) & (acc_sh[WIDTH-1] ^ amsb_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      z_q     <= z_d;
      v_q     <= v_d;
    end
  end

  assign bus.ready = (state_q != RUN);
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.Diff  = diff_q;
  assign bus.Bout  = bout_q;
  assign bus.Z     = z_q;
  assign bus.V     = v_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl at WIDTH=8: vector table plus handshake,
// abort and reset corner sequences.
`timescale 1ns/1ps
module tb_serial_sub_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_sub_ctrl_if #(.WIDTH(W)) bus ();
  serial_sub_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         z;
    logic         v;
  } vec_t;

  vec_t vecs[18];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Drive an accepted start; returns at the first negedge after the accept edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    bus.start  = 1'b1;
    bus.A_in   = a;
    bus.B_in   = b;
    bus.Bin_in = bin;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_res(input string nm, input vec_t v);
    check({nm, ".diff"}, int'(bus.Diff), int'(v.diff));
    check({nm, ".bout"}, int'(bus.Bout), int'(v.bout));
    check({nm, ".z"},    int'(bus.Z),    int'(v.z));
    check({nm, ".v"},    int'(bus.V),    int'(v.v));
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int n;
    start_op(v.a, v.b, v.bin);
    wait_done(n);
    check({nm, ".latency"}, n, W);
    check_res(nm, v);
  endtask

  // Run W+3 cycles after an accept with optional start pulses or abort; counts done pulses.
  task automatic run_cycles(input int start_at0, input int start_at1, input int abort_at,
                            output int dones, output int first_done);
    dones = 0;
    first_done = -1;
    for (int i = 1; i <= W + 3; i++) begin
      bus.start = (i == start_at0) || (i == start_at1);
      bus.abort = (i == abort_at);
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (i == abort_at) begin
        check("abort.ready", int'(bus.ready), 1);
        check("abort.busy",  int'(bus.busy),  0);
      end
      if (bus.done) begin
        dones++;
        if (first_done < 0) first_done = i;
      end
    end
  endtask

  initial begin
    int n, dones, fd;
    vec_t prev;
    //        a      b      bin   diff   bout  z     v
    vecs[0]  = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{8'h42, 8'h42, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{8'hFF, 8'h01, 1'b1, 8'hFD, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    // LSB sweep of (a,b,bin) against the cell truth table
    vecs[10] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{8'h00, 8'h01, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{8'h01, 8'h01, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};

    bus.start = 1'b0; bus.abort = 1'b0;
    bus.A_in = '0; bus.B_in = '0; bus.Bin_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.ready", int'(bus.ready), 1);
    check("rst.busy",  int'(bus.busy),  0);
    check("rst.done",  int'(bus.done),  0);
    check_res("rst", '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 18; k++) begin
      run_vec($sformatf("vec%0d", k), vecs[k]);
      @(negedge clk);
      check($sformatf("vec%0d.done_pulse", k), int'(bus.done), 0);
    end

    // start pulses mid-RUN are ignored
    start_op(8'hFF, 8'h00, 1'b0);
    bus.A_in = 8'h11; bus.B_in = 8'h22;
    run_cycles(3, 5, 0, dones, fd);
    check("pulse.dones", dones, 1);
    check("pulse.when",  fd, W);
    check_res("pulse", '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0});

    // start held across DONE: second op with no IDLE cycle
    start_op(8'h10, 8'h01, 1'b0);
    for (int i = 1; i <= W; i++) begin
      if (i == W - 1) begin
        bus.start = 1'b1; bus.A_in = 8'h20; bus.B_in = 8'h05; bus.Bin_in = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b.done1", int'(bus.done), 1);
    check_res("b2b.op1", '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b.busy", int'(bus.busy), 1);
    wait_done(n);
    check("b2b.latency", n, W);
    check_res("b2b.op2", '{8'h20, 8'h05, 1'b0, 8'h1B, 1'b0, 1'b0, 1'b0});

    // abort at RUN cycle 4 holds previous results
    prev = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
    run_vec("pre_abort", prev);
    start_op(8'h03, 8'h05, 1'b0);
    run_cycles(0, 0, 4, dones, fd);
    check("abort4.dones", dones, 0);
    check_res("abort4.hold", prev);
    run_vec("post_abort", vecs[1]);

    // abort on the final bit beats completion
    start_op(8'h42, 8'h42, 1'b0);
    run_cycles(0, 0, W, dones, fd);
    check("abort_last.dones", dones, 0);
    check_res("abort_last.hold", vecs[1]);

    // async reset mid-RUN
    start_op(8'h05, 8'h03, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst.ready", int'(bus.ready), 1);
    check("midrst.busy",  int'(bus.busy),  0);
    check_res("midrst", '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    #1 rst = 1'b0;
    run_cycles(0, 0, 0, dones, fd);
    check("midrst.dones", dones, 0);
    run_vec("post_rst", vecs[3]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
